// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester, memory and counter signals of the two-port memory arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
);
    logic              p0_enable_i;
    logic              p0_write_i;
    logic [ADDR_W-1:0] p0_addr_i;
    logic [DATA_W-1:0] p0_data_i;
    logic              p0_ack_o;
    logic [DATA_W-1:0] p0_data_o;
    logic [CNT_W-1:0]  p0_count_o;

    logic              p1_enable_i;
    logic              p1_write_i;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [DATA_W-1:0] p1_data_i;
    logic              p1_ack_o;
    logic [DATA_W-1:0] p1_data_o;
    logic [CNT_W-1:0]  p1_count_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [DATA_W-1:0] mem_data_i;

    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  mem_ack_i, mem_data_i,
        output p0_ack_o, p0_data_o, p0_count_o,
        output p1_ack_o, p1_data_o, p1_count_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output mem_ack_i, mem_data_i,
        input  p0_ack_o, p0_data_o, p0_count_o,
        input  p1_ack_o, p1_data_o, p1_count_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one line-wide memory port between two requesters
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 256,
    parameter int CNT_W  = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_take;
    logic              w_sel;
    logic              w_done;
    logic              r_grant;
    logic              r_last;
    logic              r_write;
    logic              r_mem_enable;
    logic              r_p0_ack;
    logic              r_p1_ack;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;
    logic [CNT_W-1:0]  r_p0_count;
    logic [CNT_W-1:0]  r_p1_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_take       = 1'b0;
        w_sel        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // on a tie the port that was not served last wins
                if (bus.p0_enable_i && bus.p1_enable_i) begin
                    w_sel = ~r_last;
                end else begin
                    w_sel = bus.p1_enable_i;
                end
                if (bus.p0_enable_i || bus.p1_enable_i) begin
                    w_take       = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.mem_ack_i) begin
                    w_next_state = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_done = (r_state == S_BUSY) && bus.mem_ack_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_grant      <= 1'b0;
            r_last       <= 1'b1;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_mem_enable <= 1'b0;
            r_p0_ack     <= 1'b0;
            r_p1_ack     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_rdata   <= '0;
            r_p0_count   <= '0;
            r_p1_count   <= '0;
        end else begin
            // enable follows the next state so it is high for exactly the BUSY cycles
            r_mem_enable <= (w_next_state == S_BUSY);
            r_p0_ack     <= w_done && !r_grant;
            r_p1_ack     <= w_done && r_grant;
            if (w_take) begin
                r_grant <= w_sel;
                r_last  <= w_sel;
                r_write <= w_sel ? bus.p1_write_i : bus.p0_write_i;
                r_addr  <= w_sel ? bus.p1_addr_i  : bus.p0_addr_i;
                r_data  <= w_sel ? bus.p1_data_i  : bus.p0_data_i;
            end
            if (w_done) begin
                if (r_grant) begin
                    r_p1_rdata <= bus.mem_data_i;
                    r_p1_count <= r_p1_count + CNT_W'(1);
                end else begin
                    r_p0_rdata <= bus.mem_data_i;
                    r_p0_count <= r_p0_count + CNT_W'(1);
                end
            end
        end
    end

    assign bus.mem_enable_o = r_mem_enable;
    assign bus.mem_write_o  = r_write;
    assign bus.mem_addr_o   = r_addr;
    assign bus.mem_data_o   = r_data;
    assign bus.p0_ack_o     = r_p0_ack;
    assign bus.p1_ack_o     = r_p1_ack;
    assign bus.p0_data_o    = r_p0_rdata;
    assign bus.p1_data_o    = r_p1_rdata;
    assign bus.p0_count_o   = r_p0_count;
    assign bus.p1_count_o   = r_p1_count;
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter sharing the single 256-bit Data_Memory port between the data cache (port 0) and a second line-fill client such as an instruction cache or DMA (port 1). It sits between the CPU-side cache controllers and Data_Memory, replacing the direct dcache-to-memory connection. It latches one whole request per grant, drives the memory enable/write/addr/data handshake, and returns the memory response and a one-cycle ack to the granted port. Contention is resolved round-robin, and a completed-transaction counter is kept per port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 256, cache-line / memory data width
- CNT_W, 16, width of per-port transaction counters
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  reset; synchronous, active-high
- pN_enable_i  input  1  request valid, port N (N = 0, 1)
- pN_write_i  input  1  1 = write line, 0 = read line
- pN_addr_i  input  ADDR_W  line address
- pN_data_i  input  DATA_W  write data
- pN_ack_o  output  1  one-cycle completion pulse
- pN_data_o  output  DATA_W  read data, valid while pN_ack_o = 1
- pN_count_o  output  CNT_W  completed transactions on port N, wraps modulo 2^CNT_W
- mem_enable_o  output  1  memory request
- mem_write_o  output  1  memory write
- mem_addr_o  output  ADDR_W  memory address
- mem_data_o  output  DATA_W  memory write data
- mem_ack_i  input  1  memory completion, one-cycle pulse
- mem_data_i  input  DATA_W  memory read data, valid with mem_ack_i

## Operation
- **States:** IDLE, BUSY, RELEASE. Registers: grant (1 bit), last (1 bit), latched write/addr/data, response data, two counters.
- **IDLE:**
  - No enable asserted: stay in IDLE.
  - Exactly one enable asserted: grant that port.
  - Both asserted: grant the port != last.
  - On grant: latch that port's write/addr/data, set grant and last, go to BUSY.
- **BUSY:**
  - mem_enable_o = 1; mem_write_o/addr/data come from the latched copy.
  - Input changes on either port are ignored, including a requester dropping enable.
  - On mem_ack_i = 1: capture mem_data_i into the response register, increment the granted port's counter, go to RELEASE.
- **RELEASE (exactly one cycle):**
  - mem_enable_o = 0; p[grant]_ack_o = 1; p[grant]_data_o = captured data.
  - Data is captured for writes too; its content is don't-care.
  - Next state: IDLE.
- **Requester obligations:**
  - Hold enable until ack.
  - An enable still high in the IDLE cycle after RELEASE is a new request.
- **Fairness:** a port waits at most one transaction while the other port is continuously requesting.
- pN_data_o holds its last captured value outside ack; only port grant's copy updates.
- Counters increment exactly once per mem_ack_i sampled in BUSY. A mem_ack_i seen in IDLE or RELEASE is ignored; no counter changes.

## Timing
- **Reset values (rst_i = 1 at an edge):** state = IDLE, last = 1 (port 0 wins first tie), grant = 0, mem_enable_o = 0, mem_write_o = 0, mem_addr_o = 0, mem_data_o = 0, both ack = 0, both data_o = 0, both counts = 0.
- **Reset mid-transaction:** the transaction is abandoned; mem_enable_o is 0 from the next cycle; no ack is issued; counters clear.
- **Registered outputs:** all outputs are registered; no combinational path from any input to any output.
- **Latency:**
  - Request seen in IDLE in cycle 0: mem_enable_o = 1 from cycle 1.
  - mem_ack_i high in cycle k: port ack in cycle k+1, IDLE in cycle k+2.
  - Minimum request-to-ack is 2 cycles (memory acking in cycle 1).
- **Gap between transactions:** mem_enable_o drops for at least one cycle (RELEASE) between back-to-back transactions, so memory always sees a fresh enable edge.
- **Back-to-back throughput:** one transaction per (memory latency + 2) cycles.

## Test plan
- **Single read, port 0:** addr 0x00000000, Data_Memory[0] = 0x5 -> mem_enable_o rises one cycle after request; p0_ack_o pulses once; p0_data_o = 0x...05; p0_count_o = 1; p1 outputs unchanged.
- **Simultaneous requests after reset:** p0 write 0x20, p1 read 0x400 -> p0 served first. mem_enable_o is low for exactly one cycle between the two transactions. Then p1 is served. Counts = 1/1; the second grant is to p1.
- **Continuous contention, 6 transactions:** both enables held high and re-asserted after each ack -> grant order 0,1,0,1,0,1; counts = 3/3.
- **Request withdrawal:** p1 drops enable and changes addr to 0x40 mid-BUSY -> memory still sees the original addr until ack; p1_ack_o still pulses; p1_count_o increments.
- **Reset mid-BUSY:** assert rst_i two cycles into a p0 read -> next cycle mem_enable_o = 0, no p0_ack_o, counts = 0. After reset release, a new p1 request is served normally.
- **Counter wrap and spurious ack:** preload/run p0 to 0xFFFF, complete one more -> p0_count_o = 0x0000. A mem_ack_i pulse in IDLE changes no output.
